mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 33 +++
 rtl/mem_arbiter_flipflop.sv | 30 +++
 rtl/mem_arbiter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// ============================================================================
// Module      : mem_arbiter_pkg
// Description : Shared widths and FSM state encoding for the I/D memory
//               arbiter. Supplies the ICACHE_* width defaults when the
//               surrounding build has not already defined them.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef ICACHE_TAG_WIDTH
`define ICACHE_TAG_WIDTH 32
`endif
`ifndef ICACHE_LINE_WIDTH
`define ICACHE_LINE_WIDTH 128
`endif

package mem_arbiter_pkg;

  localparam int unsigned C_DEF_ADDR_W = `ICACHE_TAG_WIDTH;
  localparam int unsigned C_DEF_LINE_W = `ICACHE_LINE_WIDTH;

  // IDLE arbitrates, MEM_x waits for memory, DLV_x waits for the requester.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MEM_I = 3'd1,
    ST_MEM_D = 3'd2,
    ST_DLV_I = 3'd3,
    ST_DLV_D = 3'd4
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_flipflop.sv
// ============================================================================
// Module      : mem_arbiter_flipflop
// Description : Generic load-enabled register with asynchronous active-low
//               clear, used for the latched request and the captured line.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter_flipflop #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  // Hold value unless loaded; reset clears immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_q <= '0;
    end else if (i_en) begin
      o_q <= i_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module      : mem_arbiter
// Description : Arbitrates I-cache fills and D-cache fills/writebacks onto a
//               single line-wide memory port. One transaction at a time:
//               IDLE -> MEM_x (memory busy) -> DLV_x (hand-off) -> IDLE.
//               Build option ARB_ROUND_ROBIN_EN: contention alternates
//               between requesters; otherwise D always beats I.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef ICACHE_TAG_WIDTH
`define ICACHE_TAG_WIDTH 32
`endif
`ifndef ICACHE_LINE_WIDTH
`define ICACHE_LINE_WIDTH 128
`endif

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = `ICACHE_TAG_WIDTH,
  parameter int LINE_W = `ICACHE_LINE_WIDTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reqI_mem,
  input  logic [ADDR_W-1:0] reqAddrI_mem,
  input  logic              reqD_mem,
  input  logic              reqD_we,
  input  logic [ADDR_W-1:0] reqAddrD_mem,
  input  logic [LINE_W-1:0] reqD_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_rdy,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic              i_data_rdy,
  output logic              d_data_rdy,
  output logic [LINE_W-1:0] line_out,
  input  logic              i_filled_ack,
  input  logic              d_filled_ack,
  output logic              busy
);

  arb_state_t        r_state;
  arb_state_t        w_next;
  logic              w_grant_d;
  logic              w_grant_i;
  logic              w_load;
  logic              w_cap;
  logic              r_we;
  logic [ADDR_W-1:0] w_addr_d;
  logic [LINE_W-1:0] w_wdata_d;
  logic              w_we_d;

`ifdef ARB_ROUND_ROBIN_EN
  // 1 = D was served last; reset value means I was served last.
  logic r_last_d;

  // Under contention, serve whoever was not served last.
  always_comb begin
    w_grant_d = reqD_mem & (~reqI_mem | ~r_last_d);
    w_grant_i = reqI_mem & ~w_grant_d;
  end

  // Remember the winner of every grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_d <= 1'b0;
    end else if (w_load) begin
      r_last_d <= w_grant_d;
    end
  end
`else
  // Fixed priority: D wins whenever it is requesting.
  always_comb begin
    w_grant_d = reqD_mem;
    w_grant_i = reqI_mem & ~reqD_mem;
  end
`endif

  // Grants happen only from IDLE; the winner's request is snapshotted so
  // later changes on the request inputs cannot disturb the transaction.
  assign w_load    = (r_state == ST_IDLE) & (w_grant_d | w_grant_i);
  assign w_addr_d  = w_grant_d ? reqAddrD_mem : reqAddrI_mem;
  assign w_we_d    = w_grant_d & reqD_we;
  assign w_wdata_d = w_grant_d ? reqD_wdata : '0;

  // Fill data is captured only for reads; a writeback leaves line_out alone.
  assign w_cap = mem_rdy & ((r_state == ST_MEM_I) | ((r_state == ST_MEM_D) & ~r_we));

  mem_arbiter_flipflop #(.WIDTH(ADDR_W)) u_addr_ff (
    .clk(clk), .reset(reset), .i_en(w_load), .i_d(w_addr_d), .o_q(mem_addr)
  );

  mem_arbiter_flipflop #(.WIDTH(1)) u_we_ff (
    .clk(clk), .reset(reset), .i_en(w_load), .i_d(w_we_d), .o_q(r_we)
  );

  mem_arbiter_flipflop #(.WIDTH(LINE_W)) u_wdata_ff (
    .clk(clk), .reset(reset), .i_en(w_load), .i_d(w_wdata_d), .o_q(mem_wdata)
  );

  mem_arbiter_flipflop #(.WIDTH(LINE_W)) u_line_ff (
    .clk(clk), .reset(reset), .i_en(w_cap), .i_d(mem_rdata), .o_q(line_out)
  );

  // State register; reset aborts any in-flight transaction at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and state-decoded outputs; stray mem_rdy/acks fall through.
  always_comb begin
    w_next     = r_state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    i_data_rdy = 1'b0;
    d_data_rdy = 1'b0;
    busy       = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE: begin
        if (w_grant_d) begin
          w_next = ST_MEM_D;
        end else if (w_grant_i) begin
          w_next = ST_MEM_I;
        end
      end
      ST_MEM_I: begin
        mem_req = 1'b1;
        if (mem_rdy) begin
          w_next = ST_DLV_I;
        end
      end
      ST_MEM_D: begin
        mem_req = 1'b1;
        mem_we  = r_we;
        if (mem_rdy) begin
          w_next = ST_DLV_D;
        end
      end
      ST_DLV_I: begin
        i_data_rdy = 1'b1;
        if (i_filled_ack) begin
          w_next = ST_IDLE;
        end
      end
      ST_DLV_D: begin
        d_data_rdy = 1'b1;
        if (d_filled_ack) begin
          w_next = ST_IDLE;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire
